derrita_histogram: RTL and testbench
====================================

# derrita_histogram

Downstream stage of the per-PE GRN Hamming-distance pipeline. It consumes each (initial-state distance, successor-state distance) pair that the PE emits and counts occurrences in a 2D histogram RAM, one bin per pair. When the PE signals completion, it streams every bin out with a valid/ready handshake, producing the raw Derrida-plot counts for that PE.

## Interface
- DIST_W, 3, width of each distance value; histogram depth is DEPTH = 2^(2*DIST_W).
- CNT_W, 32, width of each bin counter.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- in_valid  in  1  distance pair present this cycle.
- in_addr_dist  in  DIST_W  distance between the initial states (row).
- in_data_dist  in  DIST_W  distance between the successor states (column).
- in_ready  out  1  block accepts pairs; a pair is taken when in_valid && in_ready.
- in_done  in  1  PE finished producing pairs; level, held high.
- out_valid  out  1  out_bin/out_count valid.
- out_ready  in  1  consumer accepts the word.
- out_bin  out  2*DIST_W  bin index {row, column}.
- out_count  out  CNT_W  count for out_bin.
- out_last  out  1  high with the word for bin DEPTH-1.
- done  out  1  drain complete; sticky until reset.

## Operation
- Bin index = {in_addr_dist, in_data_dist}. Example: row 2, column 3 gives bin 19 at DIST_W=3.
- States:
  - CLEAR: entered on reset. Writes 0 to bins 0..DEPTH-1, one per cycle, in DEPTH cycles. in_ready=0. Then goes to ACCUM.
  - ACCUM: in_ready=1. Each accepted pair increments its bin. When in_done=1, no pair is accepted that cycle, and the pipeline is empty, goes to DRAIN.
  - DRAIN: in_ready=0. Emits bins 0..DEPTH-1 in order. After the word with out_last is accepted, goes to DONE.
  - DONE: done=1, in_ready=0, out_valid=0. Stays until reset.
- An in_done assertion during CLEAR is honoured after CLEAR completes.
- A pair that arrives together with the first in_done cycle is counted before the flush.
- Increment is a 2-stage read-modify-write:
  - Stage 1 reads the RAM.
  - Stage 2 writes count+1.
  - Forwarding: if the stage-2 write index equals the stage-1 index, stage 1 uses the stage-2 new value. Back-to-back pairs to the same bin therefore count exactly.
- in_valid while in_ready=0 is ignored; nothing is counted.
- Increment is modulo 2^CNT_W unless saturation is compiled in (see Configuration).

## Timing
- Reset values: in_ready=0, out_valid=0, out_bin=0, out_count=0, out_last=0, done=0. All internal counters and the pipeline valids are 0.
- Reset low in any state, including mid-ACCUM or mid-DRAIN: the next cycle has all outputs at reset values and CLEAR restarts from bin 0.
- in_ready rises on the cycle after the last CLEAR write: DEPTH+1 cycles after rst goes high.
- Accumulation latency: a pair accepted at cycle N has its bin updated in the RAM at the end of cycle N+2.
- Throughput: one pair per cycle, sustained.
- The ACCUM->DRAIN transition waits the 2-cycle pipeline flush.
- DRAIN output:
  - The RAM read latency is 1 cycle; the output is registered.
  - The first out_valid is high 2 cycles after entering DRAIN.
  - While out_valid && !out_ready, out_bin, out_count and out_last hold stable.
  - With out_ready held at 1, one word is emitted per cycle, DEPTH words in total.
- done rises on the cycle after the out_last word is accepted.

## Configuration
- DERRITA_HIST_SAT_EN defined: a bin already at 2^CNT_W-1 stays at 2^CNT_W-1 when incremented, forwarding path included.
- DERRITA_HIST_SAT_EN undefined: a bin wraps to 0 on overflow.

## Structure
- Shared package derrita_pkg holds:
  - the state enum (CLEAR, ACCUM, DRAIN, DONE);
  - the DEPTH derivation from DIST_W;
  - default parameter constants for DIST_W and CNT_W.
- One sub-module, derrita_hist_ram: simple dual-port RAM with DEPTH words of CNT_W bits, one write port, one registered read port, 1-cycle read latency. It is instantiated once.
- FSM, RMW pipeline, forwarding and drain logic live in derrita_histogram.

## Test plan
- Reset, DIST_W=3 -> in_ready=0 for 64 cycles after rst goes high, then 1; all outputs 0 during reset.
- Single pair (2,3) then in_done, out_ready=1 -> 64 words in bin order; bin 19 count 1, all others 0; out_last only on bin 63; done=1 afterwards.
- Five consecutive-cycle pairs (1,1) plus one pair (1,2) -> bin 9 count 5, bin 10 count 1.
- Drain with out_ready pattern 1,0,1,0 -> each bin emitted exactly once, fields stable during stalls, 64 accepted words.
- CNT_W=2, five pairs to bin 0 -> count 3 with DERRITA_HIST_SAT_EN defined, count 1 without.
- rst pulsed low after 10 drain words -> outputs at reset values the next cycle, CLEAR reruns, and a subsequent in_done drains 64 zero counts.

Source files
------------

// File: rtl/derrita_pkg.sv
// Shared types and sizing for the Derrida histogram block: FSM state encoding,
// default widths and the bin-count derivation from the distance width.
package derrita_pkg;

    localparam int DIST_W_DEF = 3;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int depth_of(input int dist_w);
        return 1 << (2 * dist_w);
    endfunction

endpackage

// File: rtl/derrita_hist_ram.sv
// Histogram storage: one write port, one registered read port with read enable.
// A read that hits the address being written in the same cycle returns the new data.
module derrita_hist_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_wr_addr] <= i_wr_data;
        // write-first on collision keeps a read issued alongside the RMW write coherent
        if (i_rd_en)
            r_rd_data <= (i_we && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/derrita_histogram.sv
// 2D Derrida histogram: clears the bin RAM, counts (row, column) distance pairs with a
// forwarded 2-stage read-modify-write, then streams every bin out. Saturating counters
// are compiled in with DERRITA_HIST_SAT_EN; otherwise bins wrap.
//
//   state | meaning
//   CLEAR | zero bins 0..DEPTH-1, one per cycle
//   ACCUM | accept pairs, increment bins
//   DRAIN | stream bins 0..DEPTH-1 over out_valid/out_ready
//   DONE  | drain finished, idle until reset
module derrita_histogram
    import derrita_pkg::*;
#(
    parameter int DIST_W = DIST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DIST_W-1:0]   in_addr_dist,
    input  logic [DIST_W-1:0]   in_data_dist,
    output logic                in_ready,
    input  logic                in_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DIST_W-1:0] out_bin,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_last,
    output logic                done
);

    localparam int BIN_W = 2 * DIST_W;
    localparam int DEPTH = depth_of(DIST_W);
    localparam logic [BIN_W-1:0] LAST_BIN = {BIN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e             r_state, w_next;
    logic [BIN_W-1:0]   r_idx;
    logic               r_issue_done;
    logic               r_s1_valid, r_s2_valid;
    logic [BIN_W-1:0]   r_s1_bin, r_s2_bin;
    logic [CNT_W-1:0]   r_s2_cnt;
    logic               r_pend;
    logic [BIN_W-1:0]   r_pend_bin;
    logic               r_out_valid, r_out_last;
    logic [BIN_W-1:0]   r_out_bin;
    logic [CNT_W-1:0]   r_out_cnt;

    logic [BIN_W-1:0]   w_bin, w_rd_addr, w_wr_addr;
    logic [CNT_W-1:0]   w_rd_data, w_wr_data, w_base, w_inc;
    logic               w_accept, w_we, w_rd_en;
    logic               w_drain_load, w_drain_issue, w_out_fire;

    assign w_bin    = {in_addr_dist, in_data_dist};
    assign w_accept = in_valid && in_ready;

    // stage 2 holds the newest value of its bin until its write lands
    assign w_base = (r_s2_valid && (r_s2_bin == r_s1_bin)) ? r_s2_cnt : w_rd_data;
`ifdef DERRITA_HIST_SAT_EN
    assign w_inc = (w_base == CNT_MAX) ? w_base : w_base + CNT_W'(1);
`else
    assign w_inc = w_base + CNT_W'(1);
`endif

    assign w_drain_load  = r_pend && (!r_out_valid || out_ready);
    assign w_drain_issue = (r_state == DRAIN) && !r_issue_done && (!r_pend || w_drain_load);
    assign w_out_fire    = r_out_valid && out_ready;

    assign w_we      = (r_state == CLEAR) || r_s2_valid;
    assign w_wr_addr = (r_state == CLEAR) ? r_idx : r_s2_bin;
    assign w_wr_data = (r_state == CLEAR) ? '0 : r_s2_cnt;
    assign w_rd_en   = w_accept || w_drain_issue;
    assign w_rd_addr = (r_state == DRAIN) ? r_idx : w_bin;

    derrita_hist_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (BIN_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= CLEAR;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            CLEAR: if (r_idx == LAST_BIN) w_next = ACCUM;
            ACCUM: if (in_done && !w_accept && !r_s1_valid && !r_s2_valid) w_next = DRAIN;
            DRAIN: if (w_out_fire && r_out_last) w_next = DONE;
            DONE:  w_next = DONE;
            default: w_next = CLEAR;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ACCUM);
        done     = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx        <= '0;
            r_issue_done <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_bin     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_bin     <= '0;
            r_s2_cnt     <= '0;
            r_pend       <= 1'b0;
            r_pend_bin   <= '0;
            r_out_valid  <= 1'b0;
            r_out_bin    <= '0;
            r_out_cnt    <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_bin   <= w_bin;
            r_s2_valid <= r_s1_valid;
            r_s2_bin   <= r_s1_bin;
            r_s2_cnt   <= w_inc;

            // the clear index wraps to 0, which is where the drain starts
            if (r_state == CLEAR || w_drain_issue)
                r_idx <= r_idx + BIN_W'(1);
            if (w_drain_issue && r_idx == LAST_BIN)
                r_issue_done <= 1'b1;

            if (w_drain_issue) begin
                r_pend     <= 1'b1;
                r_pend_bin <= r_idx;
            end else if (w_drain_load) begin
                r_pend <= 1'b0;
            end

            if (w_drain_load) begin
                r_out_valid <= 1'b1;
                r_out_bin   <= r_pend_bin;
                r_out_cnt   <= w_rd_data;
                r_out_last  <= (r_pend_bin == LAST_BIN);
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_count = r_out_cnt;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_derrita_histogram.sv
// Scoreboard bench for derrita_histogram: a 32-bit-counter instance and a 2-bit-counter
// instance share one stimulus stream and are checked against a plain-array pair count.
module tb_derrita_histogram;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_done = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_addr_dist = '0;
    logic [2:0] in_data_dist = '0;

    logic        m_in_ready, m_out_valid, m_out_last, m_done;
    logic [5:0]  m_out_bin;
    logic [31:0] m_out_count;
    logic        s_in_ready, s_out_valid, s_out_last, s_done;
    logic [5:0]  s_out_bin;
    logic [1:0]  s_out_count;

    always #5 clk = ~clk;

    derrita_histogram #(.DIST_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr_dist(in_addr_dist),
        .in_data_dist(in_data_dist), .in_ready(m_in_ready), .in_done(in_done),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_bin(m_out_bin),
        .out_count(m_out_count), .out_last(m_out_last), .done(m_done));

    derrita_histogram #(.DIST_W(3), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr_dist(in_addr_dist),
        .in_data_dist(in_data_dist), .in_ready(s_in_ready), .in_done(in_done),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_bin(s_out_bin),
        .out_count(s_out_count), .out_last(s_out_last), .done(s_done));

    typedef struct {
        logic [5:0]  bin;
        logic [31:0] cnt;
        logic        last;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   hist[64];
    exp_t q_m[$];
    exp_t q_s[$];
    int   acc_m = 0;
    int   acc_s = 0;

    logic        hold[2];
    logic [5:0]  hb[2];
    logic [31:0] hc[2];
    logic        hl[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: a bin's count is the number of accepted pairs, reduced to the counter width
    function automatic logic [31:0] small_cnt(input int h);
`ifdef DERRITA_HIST_SAT_EN
        return (h > 3) ? 32'd3 : 32'(h);
`else
        return 32'(h % 4);
`endif
    endfunction

    always @(negedge clk)
        if (rst && in_valid && m_in_ready)
            hist[{in_addr_dist, in_data_dist}]++;

    task automatic mon(input int k, input logic v, input logic [5:0] b,
                       input logic [31:0] c, input logic l);
        exp_t e;
        if (hold[k])
            chk($sformatf("dut%0d_stall_stable", k), {29'd0, v, l, b, c}, {29'd0, 1'b1, hl[k], hb[k], hc[k]});
        if (v && out_ready) begin
            if ((k == 0 && q_m.size() == 0) || (k == 1 && q_s.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d_unexpected_word: got bin %0d count %0d, none required", k, b, c);
            end else begin
                if (k == 0) begin e = q_m.pop_front(); acc_m++; end
                else        begin e = q_s.pop_front(); acc_s++; end
                chk($sformatf("dut%0d_bin", k), 64'(b), 64'(e.bin));
                chk($sformatf("dut%0d_count_bin%0d", k, e.bin), 64'(c), 64'(e.cnt));
                chk($sformatf("dut%0d_last_bin%0d", k, e.bin), 64'(l), 64'(e.last));
            end
        end
        hold[k] = v && !out_ready;
        hb[k] = b;
        hc[k] = c;
        hl[k] = l;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, m_out_valid, m_out_bin, m_out_count, m_out_last);
            mon(1, s_out_valid, s_out_bin, {30'd0, s_out_count}, s_out_last);
        end
    end

    task automatic push_expected();
        for (int b = 0; b < 64; b++) begin
            exp_t e;
            e.bin  = 6'(b);
            e.last = (b == 63);
            e.cnt  = 32'(hist[b]);
            q_m.push_back(e);
            e.cnt  = small_cnt(hist[b]);
            q_s.push_back(e);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset_outputs_m", {26'd0, m_in_ready, m_out_valid, m_out_last, m_done, m_out_bin, m_out_count}, 64'd0);
        chk("reset_outputs_s", {56'd0, s_in_ready, s_out_valid, s_out_last, s_done, s_out_bin, s_out_count}, 64'd0);
    endtask

    task automatic flush_model();
        for (int b = 0; b < 64; b++) hist[b] = 0;
        q_m.delete();
        q_s.delete();
        acc_m = 0;
        acc_s = 0;
    endtask

    // counts clock edges after rst rises until in_ready appears
    task automatic wait_clear(input int start);
        int n = start;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_in_ready && n < 200);
        chk("clear_cycles", 64'(n), 64'd64);
        chk("clear_ready_s", 64'(s_in_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        wait_clear(0);
    endtask

    task automatic send(input int r, input int c);
        in_valid = 1'b1;
        in_addr_dist = 3'(r);
        in_data_dist = 3'(c);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic random_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                in_addr_dist = 3'd3;
                in_data_dist = 3'd4;
            end else begin
                in_addr_dist = 3'($urandom_range(0, 7));
                in_data_dist = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: ready always, 1: ready 1,0,1,0..., 2: random; stop_after>0 returns early
    task automatic run_drain(input int mode, input int stop_after);
        int cyc = 0;
        in_done = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_expected();
        while (!m_done && cyc < 3000 && !(stop_after > 0 && acc_m >= stop_after)) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        if (stop_after == 0) begin
            chk("done_m", 64'(m_done), 64'd1);
            chk("done_s", 64'(s_done), 64'd1);
            chk("words_m", 64'(acc_m), 64'd64);
            chk("words_s", 64'(acc_s), 64'd64);
            chk("queues_empty", 64'(q_m.size() + q_s.size()), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("done_idle", {60'd0, m_done, m_out_valid, m_in_ready, s_out_valid}, {60'd0, 4'b1000});
        end
    endtask

    initial begin
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b1;
        wait_clear(0);

        send(2, 3);
        run_drain(0, 0);
        in_done = 1'b0;
        do_reset();

        repeat (5) send(1, 1);
        send(1, 2);
        chk("model_bin9", 64'(hist[9]), 64'd5);
        run_drain(0, 0);
        in_done = 1'b0;
        do_reset();

        repeat (5) send(0, 0);
        random_pairs(300);
        in_valid = 1'b1;
        in_addr_dist = 3'd7;
        in_data_dist = 3'd7;
        run_drain(1, 0);
        in_done = 1'b0;
        do_reset();

        random_pairs(200);
        run_drain(2, 10);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs();
        flush_model();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_addr_dist = 3'd5;
        in_data_dist = 3'd5;
        repeat (30) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_clear(30);
        run_drain(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
